// File: rtl/pipelined_addsub_if.sv
// Operand (in_*) and result (out_*) handshake bundle for pipelined_addsub.
// in_sat is present only when PIPELINED_ADDSUB_SAT_EN is defined.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
`ifdef PIPELINED_ADDSUB_SAT_EN
  logic             in_sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
`ifdef PIPELINED_ADDSUB_SAT_EN
    output in_sat,
`endif
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, out_tag
  );

  modport slave (
`ifdef PIPELINED_ADDSUB_SAT_EN
    input  in_sat,
`endif
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_ovf, out_zero, out_tag
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one BLOCK-bit slice per stage, registered carry, latency WIDTH/BLOCK.
// Optional signed saturation is enabled with the macro PIPELINED_ADDSUB_SAT_EN.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int TAG_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / BLOCK;

  logic             advance;
  logic             out_valid_reg;
  logic             out_carry_reg;
  logic             out_ovf_reg;
  logic             out_zero_reg;
  logic [WIDTH-1:0] out_result_reg;
  logic [TAG_W-1:0] out_tag_reg;

  // The whole pipe moves together; any stall at the output freezes every stage.
  assign advance        = !out_valid_reg || bus.out_ready;
  assign bus.in_ready   = advance;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_result = out_result_reg;
  assign bus.out_carry  = out_carry_reg;
  assign bus.out_ovf    = out_ovf_reg;
  assign bus.out_zero   = out_zero_reg;
  assign bus.out_tag    = out_tag_reg;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * BLOCK;

    logic [BLOCK-1:0]    a_sl;
    logic [BLOCK-1:0]    b_sl;
    logic [BLOCK-1:0]    s_sl;
    logic                cin;
    logic                cout;
    logic                v_in;
    logic [TAG_W-1:0]    tag_in;
    logic [LO+BLOCK-1:0] sum_w;
`ifdef PIPELINED_ADDSUB_SAT_EN
    logic                sat_in;
`endif

    assign {cout, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{BLOCK{1'b0}}, cin};

    // Subtraction enters as A + ~B with in_sub as the carry-in of slice 0.
    if (gi == 0) begin : g_src
      assign a_sl   = bus.in_a[BLOCK-1:0];
      assign b_sl   = bus.in_b[BLOCK-1:0] ^ {BLOCK{bus.in_sub}};
      assign cin    = bus.in_sub;
      assign v_in   = bus.in_valid;
      assign tag_in = bus.in_tag;
      assign sum_w  = s_sl;
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign sat_in = bus.in_sat;
`endif
    end else begin : g_src
      assign a_sl   = g_stage[gi-1].g_reg.a_hi_reg[BLOCK-1:0];
      assign b_sl   = g_stage[gi-1].g_reg.b_hi_reg[BLOCK-1:0];
      assign cin    = g_stage[gi-1].g_reg.c_reg;
      assign v_in   = g_stage[gi-1].g_reg.v_reg;
      assign tag_in = g_stage[gi-1].g_reg.tag_reg;
      assign sum_w  = {s_sl, g_stage[gi-1].g_reg.sum_reg};
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign sat_in = g_stage[gi-1].g_reg.sat_reg;
`endif
    end

    if (gi < STAGES - 1) begin : g_reg
      localparam int HI_W = WIDTH - LO - BLOCK;

      // Operand slices not yet added are skewed forward; finished sum bits are deskewed below.
      logic [HI_W-1:0]     a_hi_in;
      logic [HI_W-1:0]     b_hi_in;
      logic [HI_W-1:0]     a_hi_reg;
      logic [HI_W-1:0]     b_hi_reg;
      logic [LO+BLOCK-1:0] sum_reg;
      logic                c_reg;
      logic                v_reg;
      logic [TAG_W-1:0]    tag_reg;
`ifdef PIPELINED_ADDSUB_SAT_EN
      logic                sat_reg;
`endif

      if (gi == 0) begin : g_hi
        assign a_hi_in = bus.in_a[WIDTH-1:BLOCK];
        assign b_hi_in = bus.in_b[WIDTH-1:BLOCK] ^ {HI_W{bus.in_sub}};
      end else begin : g_hi
        assign a_hi_in = g_stage[gi-1].g_reg.a_hi_reg[WIDTH-LO-1:BLOCK];
        assign b_hi_in = g_stage[gi-1].g_reg.b_hi_reg[WIDTH-LO-1:BLOCK];
      end

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          v_reg    <= 1'b0;
          c_reg    <= 1'b0;
          sum_reg  <= '0;
          a_hi_reg <= '0;
          b_hi_reg <= '0;
          tag_reg  <= '0;
`ifdef PIPELINED_ADDSUB_SAT_EN
          sat_reg  <= 1'b0;
`endif
        end else if (advance) begin
          v_reg    <= v_in;
          c_reg    <= cout;
          sum_reg  <= sum_w;
          a_hi_reg <= a_hi_in;
          b_hi_reg <= b_hi_in;
          tag_reg  <= tag_in;
`ifdef PIPELINED_ADDSUB_SAT_EN
          sat_reg  <= sat_in;
`endif
        end
      end
    end else begin : g_out
      logic             ovf_w;
      logic [WIDTH-1:0] res_w;

      // Carry into the MSB is recovered from the MSB sum bit of the last slice.
      assign ovf_w = a_sl[BLOCK-1] ^ b_sl[BLOCK-1] ^ s_sl[BLOCK-1] ^ cout;

`ifdef PIPELINED_ADDSUB_SAT_EN
      assign res_w = (sat_in && ovf_w) ? {a_sl[BLOCK-1], {(WIDTH-1){!a_sl[BLOCK-1]}}} : sum_w;
`else
      assign res_w = sum_w;
`endif

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          out_valid_reg  <= 1'b0;
          out_result_reg <= '0;
          out_carry_reg  <= 1'b0;
          out_ovf_reg    <= 1'b0;
          out_zero_reg   <= 1'b0;
          out_tag_reg    <= '0;
        end else if (advance) begin
          out_valid_reg  <= v_in;
          out_result_reg <= res_w;
          out_carry_reg  <= cout;
          out_ovf_reg    <= ovf_w;
          out_zero_reg   <= (res_w == '0);
          out_tag_reg    <= tag_in;
        end
      end
    end
  end
endmodule
